// File: rtl/w0rm_core_pkg.sv
// w0rm_core_pkg: shared front-end state encoding and fetch defaults
package w0rm_core_pkg;
  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    FETCH      = 2'd1,
    DRAIN      = 2'd2
  } fetch_state_e;
  localparam int INST_BYTES_DEFAULT = 2;
endpackage

// File: rtl/w0rm_sync_fifo.sv
// w0rm_sync_fifo: small synchronous FIFO with clear, used for response buffer and PC tags
module w0rm_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;
  assign do_push = push_i && cnt_q != CW'(DEPTH);
  assign do_pop  = pop_i && cnt_q != '0;
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  // pointer and occupancy tracking; clear wins over push/pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset || clr_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q == AW'(DEPTH - 1) ? '0 : wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q == AW'(DEPTH - 1) ? '0 : rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage; contents are only observed while counted as valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/w0rm_core_fetch_sequencer.sv
// w0rm_core_fetch_sequencer: PC owner, fetch issue, response buffering and redirect handling
module w0rm_core_fetch_sequencer
  import w0rm_core_pkg::*;
#(
  parameter int                  DATA_WIDTH      = 32,
  parameter int                  INST_WIDTH      = 16,
  parameter int                  INST_BYTES      = INST_BYTES_DEFAULT,
  parameter int                  MAX_OUTSTANDING = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  branch_valid,
  input  logic                  flush_pipeline,
  input  logic                  next_pc_valid,
  input  logic [DATA_WIDTH-1:0] next_pc,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst_data,
  output logic [DATA_WIDTH-1:0] inst_pc,
  input  logic                  decode_ready,
  output logic                  flush_out
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  fetch_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d, tag_pc;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, buf_cnt, unused_tag_cnt;
  logic [INST_WIDTH+DATA_WIDTH-1:0] buf_rd;
  logic redirect, hs, rsp_keep, flush_q;
  assign redirect   = branch_valid && next_pc_valid && flush_pipeline;
  assign hs         = imem_req && imem_ready;
  assign rsp_keep   = imem_rsp_valid && drop_q == '0;
  assign out_d      = out_q + CW'(hs) - CW'(imem_rsp_valid);
  assign drop_d     = redirect ? out_d : drop_q - CW'(imem_rsp_valid && drop_q != '0);
  assign fetch_pc_d = redirect ? next_pc : hs ? fetch_pc_q + DATA_WIDTH'(INST_BYTES) : fetch_pc_q;
  assign imem_addr  = fetch_pc_q;
  assign inst_valid = buf_cnt != '0;
  assign inst_data  = inst_valid ? buf_rd[INST_WIDTH-1:0] : '0;
  assign inst_pc    = inst_valid ? buf_rd[INST_WIDTH+DATA_WIDTH-1:INST_WIDTH] : '0;
  assign flush_out  = flush_q;
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RESET_WAIT;
    else state_q <= state_d;
  end
  // next state: a redirect restarts sequencing, drain ends once every stale response is consumed
  always_comb begin
    state_d = redirect ? (drop_d != '0 ? DRAIN : FETCH) :
              state_q == RESET_WAIT ? FETCH :
              state_q == DRAIN && drop_d == '0 ? FETCH : state_q;
  end
  // request only in FETCH and only while in-flight plus buffered entries leave buffer room
  always_comb begin
    imem_req = state_q == FETCH && ({1'b0, out_q} + {1'b0, buf_cnt}) < (CW + 1)'(MAX_OUTSTANDING);
  end
  // PC, in-flight count, stale-response count and flush pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_VECTOR;
      out_q      <= '0;
      drop_q     <= '0;
      flush_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      flush_q    <= redirect;
    end
  end
  w0rm_sync_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(DATA_WIDTH)) u_tag (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (redirect),
    .push_i  (hs),
    .wdata_i (fetch_pc_q),
    .pop_i   (rsp_keep),
    .rdata_o (tag_pc),
    .count_o (unused_tag_cnt)
  );
  w0rm_sync_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(INST_WIDTH + DATA_WIDTH)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (redirect),
    .push_i  (rsp_keep),
    .wdata_i ({tag_pc, imem_rsp_data}),
    .pop_i   (inst_valid && decode_ready),
    .rdata_o (buf_rd),
    .count_o (buf_cnt)
  );
endmodule

// File: tb/tb_w0rm_core_fetch_sequencer.sv
// tb_w0rm_core_fetch_sequencer: directed bench with a queued instruction-memory model
module tb_w0rm_core_fetch_sequencer;
  logic        clk = 0, reset = 1;
  logic        branch_valid = 0, flush_pipeline = 0, next_pc_valid = 0;
  logic [31:0] next_pc = 0;
  logic        imem_req, imem_ready = 1, imem_rsp_valid = 0;
  logic [31:0] imem_addr, inst_pc;
  logic [15:0] imem_rsp_data = 0, inst_data;
  logic        inst_valid, decode_ready = 1, flush_out;
  logic        mem_en = 1;
  int          nchk = 0, npass = 0, flush_cnt = 0;
  logic [31:0] iss[$], got_pc[$], pend[$];
  logic [15:0] got_dat[$];

  w0rm_core_fetch_sequencer dut (
    .clk(clk), .reset(reset), .branch_valid(branch_valid), .flush_pipeline(flush_pipeline),
    .next_pc_valid(next_pc_valid), .next_pc(next_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .decode_ready(decode_ready), .flush_out(flush_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] f(input logic [31:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction
  function automatic logic [31:0] iss_at(input int i);
    return i < iss.size() ? iss[i] : 32'hDEADBEEF;
  endfunction
  function automatic logic [31:0] pc_at(input int i);
    return i < got_pc.size() ? got_pc[i] : 32'hDEADBEEF;
  endfunction
  function automatic logic [15:0] dat_at(input int i);
    return i < got_dat.size() ? got_dat[i] : 16'hDEAD;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    logic        h;
    logic [31:0] a;
    #1;
    h = imem_req && imem_ready;
    a = imem_addr;
    if (inst_valid && decode_ready) begin
      got_pc.push_back(inst_pc);
      got_dat.push_back(inst_data);
    end
    if (flush_out) flush_cnt++;
    if (h) begin
      iss.push_back(a);
      pend.push_back(a);
    end
    @(posedge clk);
    #1;
    if (mem_en && pend.size() > 0) begin
      a = pend.pop_front();
      imem_rsp_valid = 1;
      imem_rsp_data  = f(a);
    end else imem_rsp_valid = 0;
    #1;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 10 && !imem_req; k++) step();
  endtask

  task automatic redir(input logic [31:0] pc);
    branch_valid = 1; next_pc_valid = 1; flush_pipeline = 1; next_pc = pc;
    step();
    branch_valid = 0; next_pc_valid = 0; flush_pipeline = 0;
  endtask

  initial begin
    int  g0, i100, fl0;
    logic ok;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_data", inst_data, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_flush", flush_out, 0);
    reset = 0;
    #1;
    chk("wait_no_req", imem_req, 0);
    step();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);

    repeat (8) step();
    for (int i = 0; i < 4; i++) chk($sformatf("seq_iss%0d", i), iss_at(i), 32'(2 * i));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("seq_pc%0d", i), pc_at(i), 32'(2 * i));
      chk($sformatf("seq_dat%0d", i), dat_at(i), f(32'(2 * i)));
    end
    chk("seq_noflush", flush_cnt, 0);

    decode_ready = 0;
    repeat (10) step();
    chk("stall_credit", iss.size() - got_pc.size(), 2);
    chk("stall_req", imem_req, 0);
    decode_ready = 1;
    repeat (10) step();
    ok = 1;
    for (int i = 0; i < got_pc.size(); i++)
      if (got_pc[i] != 32'(2 * i) || got_dat[i] != f(32'(2 * i))) ok = 0;
    chk("stall_nolost", ok, 1);
    chk("stall_progress", got_pc.size() > 8, 1);

    mem_en = 0;
    repeat (6) step();
    chk("hold_pend", pend.size(), 2);
    chk("hold_req", imem_req, 0);
    g0 = got_pc.size();
    fl0 = flush_cnt;
    redir(32'h100);
    chk("r1_flush", flush_out, 1);
    chk("r1_valid", inst_valid, 0);
    chk("r1_req", imem_req, 0);
    mem_en = 1;
    step();
    chk("r1_flush_1w", flush_out, 0);
    chk("r1_drain_req", imem_req, 0);
    wait_req();
    chk("r1_addr", imem_addr, 32'h100);
    i100 = iss.size();
    for (int k = 0; k < 10 && got_pc.size() <= g0; k++) step();
    chk("r1_dec_pc", pc_at(g0), 32'h100);
    chk("r1_dec_dat", dat_at(g0), f(32'h100));
    chk("r1_flush_cnt", flush_cnt - fl0, 1);

    fl0 = flush_cnt;
    branch_valid = 1; next_pc_valid = 0; flush_pipeline = 1; next_pc = 32'h300;
    repeat (3) step();
    next_pc_valid = 1; flush_pipeline = 0;
    repeat (3) step();
    branch_valid = 0; next_pc_valid = 0;
    repeat (2) step();
    chk("nt_flush", flush_cnt - fl0, 0);
    ok = iss_at(i100) == 32'h100;
    for (int i = i100 + 1; i < iss.size(); i++) if (iss[i] != iss[i-1] + 2) ok = 0;
    for (int i = g0 + 1; i < got_pc.size(); i++) if (got_pc[i] != got_pc[i-1] + 2) ok = 0;
    chk("nt_sequential", ok, 1);

    for (int k = 0; k < 10 && !(imem_req && imem_rsp_valid); k++) step();
    chk("r2_coincide", imem_req && imem_rsp_valid, 1);
    g0 = got_pc.size();
    redir(32'h200);
    chk("r2_flush", flush_out, 1);
    chk("r2_valid", inst_valid, 0);
    chk("r2_drain", imem_req, 0);
    step();
    chk("r2_req", imem_req, 1);
    chk("r2_addr", imem_addr, 32'h200);
    for (int k = 0; k < 10 && got_pc.size() <= g0; k++) step();
    chk("r2_dec_pc", pc_at(g0), 32'h200);
    chk("r2_dec_dat", dat_at(g0), f(32'h200));

    redir(32'hFFFF_FFFE);
    wait_req();
    chk("wrap_hi", imem_addr, 32'hFFFF_FFFE);
    step();
    wait_req();
    chk("wrap_zero", imem_addr, 32'h0);

    mem_en = 0;
    repeat (6) step();
    redir(32'h400);
    chk("rd_flush", flush_out, 1);
    #2;
    reset = 1;
    imem_rsp_valid = 0;
    #1;
    chk("rd_req", imem_req, 0);
    chk("rd_addr", imem_addr, 0);
    chk("rd_valid", inst_valid, 0);
    chk("rd_data", inst_data, 0);
    chk("rd_pc", inst_pc, 0);
    chk("rd_flush0", flush_out, 0);
    @(posedge clk);
    #1;
    reset = 0;
    pend.delete();
    mem_en = 1;
    #1;
    chk("rd_wait", imem_req, 0);
    step();
    chk("rd_req1", imem_req, 1);
    chk("rd_addr1", imem_addr, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/w0rm_core_fetch_sequencer.md
# w0rm_core_fetch_sequencer

Instruction-fetch controller for the W0RM core: owns the program counter, issues fetch requests to instruction memory, buffers returning instructions toward decode, and applies redirects produced by `W0RM_Core_Branch` (`branch_valid`, `flush_pipeline`, `next_pc_valid`, `next_pc`). It sequences the front end so that in-flight fetches on the wrong path are discarded and downstream stages see exactly one flush pulse per taken redirect.

## Interface
- `DATA_WIDTH`, 32, address/PC width
- `INST_WIDTH`, 16, instruction word width
- `INST_BYTES`, 2, PC increment per sequential fetch
- `MAX_OUTSTANDING`, 2, max accepted-but-unanswered fetches; also response buffer depth (power of 2, ≥1)
- `RESET_VECTOR`, 0, PC loaded on reset

- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-high reset
- `branch_valid`  in  1  branch unit result valid this cycle
- `flush_pipeline`  in  1  branch unit requests flush
- `next_pc_valid`  in  1  `next_pc` is a taken target
- `next_pc`  in  DATA_WIDTH  redirect target
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  DATA_WIDTH  fetch address
- `imem_ready`  in  1  memory accepts request (handshake = `imem_req && imem_ready`)
- `imem_rsp_valid`  in  1  instruction returned, in request order, never stalled
- `imem_rsp_data`  in  INST_WIDTH  returned instruction
- `inst_valid`  out  1  instruction to decode valid
- `inst_data`  out  INST_WIDTH  instruction to decode
- `inst_pc`  out  DATA_WIDTH  address of `inst_data`
- `decode_ready`  in  1  decode accepts (transfer = `inst_valid && decode_ready`)
- `flush_out`  out  1  one-cycle flush pulse to decode/execute

## Operation
- Redirect event R = `branch_valid && next_pc_valid && flush_pipeline`. `branch_valid` with `next_pc_valid=0` (not taken) or without `flush_pipeline`: no effect.
- States: RESET_WAIT (first cycle after reset release, no request), FETCH, DRAIN.
- FETCH: `imem_req=1` when `outstanding + buf_count < MAX_OUTSTANDING`; `imem_addr = fetch_pc`. On handshake `fetch_pc += INST_BYTES` (mod 2^DATA_WIDTH, wraps silently), `outstanding++`, address pushed to PC tag queue.
- Response: `outstanding--`; if `drop_count>0` discard and `drop_count--`, else push {data, tagged pc} into buffer. Credit rule guarantees buffer never overflows; overflow is a bench assertion failure.
- Decode side: `inst_*` = buffer head; pop on transfer.
- On R (any state): `fetch_pc <= next_pc`; buffer and tag queue cleared; `drop_count <= outstanding_next` (count after this cycle's handshake/response, so a request accepted in the R cycle is also dropped); `flush_out=1` next cycle; state → DRAIN if `drop_count_next>0`, else FETCH. No request issued in R cycle's successor until state evaluated; `imem_req` in the R cycle itself still uses old `fetch_pc` and that request is dropped.
- DRAIN: `imem_req=0`; → FETCH when `drop_count` reaches 0 (response consumed this cycle counts). New R in DRAIN restarts with recomputed `drop_count`.
- R and decode transfer same cycle: transfer completes, buffer still cleared.

## Timing
- Reset values: `imem_req=0`, `imem_addr=RESET_VECTOR`, `inst_valid=0`, `inst_data=0`, `inst_pc=0`, `flush_out=0`; `fetch_pc=RESET_VECTOR`, counters 0, state RESET_WAIT.
- First `imem_req` asserted 1 cycle after reset deasserts.
- Response→`inst_valid`: 1 cycle (registered buffer write, head visible next cycle).
- R → `flush_out` high exactly cycle R+1, one cycle wide; `inst_valid=0` from R+1 until first new-path response is buffered.
- R with `outstanding_next=0`: first request to `next_pc` at R+1.
- `imem_req` held with stable `imem_addr` until accepted unless R occurs.
- Reset mid-operation: all state cleared immediately; late memory responses after reset are the memory's responsibility to suppress.

## Structure
- Shared package `w0rm_core_pkg`: state encoding constants (RESET_WAIT/FETCH/DRAIN), `INST_BYTES` default.
- One sub-module: `w0rm_sync_fifo` (depth MAX_OUTSTANDING, width INST_WIDTH+DATA_WIDTH, synchronous clear) used for the response buffer; PC tag queue is a second instance of it.

## Test plan
- Reset release, `imem_ready=1`, 1-cycle memory latency, `decode_ready=1` -> addresses 0,2,4,6 issued; decode sees pcs 0,2,4 with matching data, no `flush_out`.
- `decode_ready=0` for 10 cycles -> at most 2 requests outstanding/buffered, `imem_req` drops, no data lost on release.
- R with `next_pc=0x100` while 2 fetches outstanding -> both responses discarded, `flush_out` 1 cycle, next request at 0x100 after drain, decode next sees pc 0x100.
- `branch_valid=1, next_pc_valid=0` -> sequential fetch unchanged, no flush.
- R in same cycle as request handshake and response arrival -> `drop_count` equals post-cycle outstanding; no stale instruction reaches decode.
- `fetch_pc=0xFFFFFFFE` sequential -> next address 0x00000000; assert `reset` mid-DRAIN -> all outputs to reset values immediately.
